// File: rtl/logic_op_pkg.sv
// Shared constants and types for the logic-op arbiter and its gate unit.
package logic_op_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND     = 3'd0;
    localparam logic [OP_W-1:0] OP_OR      = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR     = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND    = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR     = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR    = 3'd5;
    localparam logic [OP_W-1:0] OP_NOT_A   = 3'd6;
    localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_op_gate_unit.sv
// Combinational bitwise gate: every function is a per-bit 2:1 mux steered by A.
module logic_op_gate_unit
    import logic_op_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y,
    output logic             illegal
);

    logic [WIDTH-1:0] sel1;
    logic [WIDTH-1:0] sel0;

    // Choose the mux legs (value when A=1, value when A=0) for the op code.
    always_comb begin
        sel1    = '0;
        sel0    = '0;
        illegal = 1'b0;
        case (op)
            OP_AND:   begin sel1 = b;  sel0 = '0; end
            OP_OR:    begin sel1 = '1; sel0 = b;  end
            OP_XOR:   begin sel1 = ~b; sel0 = b;  end
            OP_NAND:  begin sel1 = ~b; sel0 = '1; end
            OP_NOR:   begin sel1 = '0; sel0 = ~b; end
            OP_XNOR:  begin sel1 = b;  sel0 = ~b; end
            OP_NOT_A: begin sel1 = '0; sel0 = '1; end
            default:  illegal = 1'b1;
        endcase
    end

    // Per-bit mux on A; the illegal op leaves both legs at zero.
    always_comb begin
        y = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            y[i] = a[i] ? sel1[i] : sel0[i];
        end
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one registered logic-gate unit between two requesters.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic             rsp0_valid_q, rsp1_valid_q, busy_q;
    logic             ready0_c, ready1_c;
    logic             pick;
    logic [WIDTH-1:0] gate_y;
    logic             gate_illegal;

    logic_op_gate_unit #(.WIDTH(WIDTH)) u_gate (
        .a       (a_q),
        .b       (b_q),
        .op      (op_q),
        .y       (gate_y),
        .illegal (gate_illegal)
    );

    // Winner of a request: a lone requester wins, a tie goes to the one not granted last.
    assign pick = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    // Next-state and accept logic.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        data_d   = data_q;
        err_d    = err_q;
        ready0_c = 1'b0;
        ready1_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d  = pick;
                    ready0_c = ~pick;
                    ready1_c = pick;
                    op_d     = pick ? req1_op : req0_op;
                    a_d      = pick ? req1_a  : req0_a;
                    b_d      = pick ? req1_b  : req0_b;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                data_d  = gate_y;
                err_d   = gate_illegal;
                state_d = RESP;
            end
            RESP: begin
                if ((!grant_q && rsp0_ready) || (grant_q && rsp1_ready)) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is combinational in the accept cycle and forced low while in reset.
    assign req0_ready = rst_n & ready0_c;
    assign req1_ready = rst_n & ready1_c;

    // State, payload and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_q       <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            data_q       <= data_d;
            err_q        <= err_d;
            rsp0_valid_q <= (state_d == RESP) && !grant_d;
            rsp1_valid_q <= (state_d == RESP) && grant_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_data   = data_q;
    assign rsp_err    = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed self-checking bench for logic_op_arbiter.
module tb_logic_op_arbiter;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             rsp0_valid, rsp0_ready;
    logic             rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic_op_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_err} !== 6'b0 || rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b%b vld=%b%b busy=%b err=%b data=%h required all zero",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_err, rsp_data);
        end
        req0_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b rsp0_valid=%b required 0 0", busy, rsp0_valid);
        end
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'hF0; req0_b = 8'hCC;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: got ready=%b%b required req0 only", req0_ready, req1_ready);
        end
        @(negedge clk); req0_valid = 1'b0; #1;
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_exec: got vld=%b%b busy=%b required 00 1", rsp0_valid, rsp1_valid, busy);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_data !== 8'hC0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_resp: got vld=%b%b data=%h err=%b required 10 c0 0",
                     rsp0_valid, rsp1_valid, rsp_data, rsp_err);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b vld=%b%b required 0 00", busy, rsp0_valid, rsp1_valid);
        end
    endtask

    task automatic test_all_ops();
        logic [7:0] exp_data [1:6];
        exp_data[1] = 8'hFC; exp_data[2] = 8'h3C; exp_data[3] = 8'h3F;
        exp_data[4] = 8'h03; exp_data[5] = 8'hC3; exp_data[6] = 8'h0F;
        req1_a = 8'hF0; req1_b = 8'hCC;
        for (int op = 1; op <= 6; op++) begin
            req1_valid = 1'b1; req1_op = 3'(op);
            #1;
            checks++;
            if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL ops_accept_%0d: got ready=%b%b required req1 only", op, req0_ready, req1_ready);
            end
            @(negedge clk); req1_valid = 1'b0;
            @(negedge clk); #1;
            checks++;
            if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_data !== exp_data[op] || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL ops_resp_%0d: got vld=%b%b data=%h err=%b required 01 %h 0",
                         op, rsp0_valid, rsp1_valid, rsp_data, rsp_err, exp_data[op]);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_round_robin();
        int last_acc;
        int waited;
        int id;
        last_acc = -1;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'hF0; req0_b = 8'hCC;
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 8'hF0; req1_b = 8'hCC;
        #1;
        for (int n = 0; n < 4; n++) begin
            waited = 0;
            while (!(req0_ready || req1_ready) && waited < 6) begin
                @(negedge clk); #1;
                waited++;
            end
            checks++;
            if (!(req0_ready || req1_ready)) begin
                errors++;
                $display("FAIL rr_timeout_%0d: got no accept within 6 cycles required an accept", n);
            end else begin
                id = req1_ready ? 1 : 0;
                checks++;
                if (id != (n % 2) || (req0_ready && req1_ready)) begin
                    errors++;
                    $display("FAIL rr_grant_%0d: got ready=%b%b required requester %0d only",
                             n, req0_ready, req1_ready, n % 2);
                end
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 3) begin
                        errors++;
                        $display("FAIL rr_spacing_%0d: got %0d cycles required 3", n, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                @(negedge clk); #1;
                @(negedge clk); #1;
                checks++;
                if ({rsp1_valid, rsp0_valid} !== ((n % 2) ? 2'b10 : 2'b01) ||
                    rsp_data !== ((n % 2) ? 8'hFC : 8'hC0)) begin
                    errors++;
                    $display("FAIL rr_resp_%0d: got vld1/0=%b%b data=%h required id %0d data %h",
                             n, rsp1_valid, rsp0_valid, rsp_data, n % 2, (n % 2) ? 8'hFC : 8'hC0);
                end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_backpressure();
        int waited;
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 8'hF0; req0_b = 8'hCC;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'hF0; req1_b = 8'hCC;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: got ready=%b%b required req0 only", req0_ready, req1_ready);
        end
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp0_valid !== 1'b1 || rsp_data !== 8'h3C || busy !== 1'b1 || req1_ready !== 1'b0 || rsp1_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got vld=%b data=%h busy=%b req1_ready=%b rsp1_valid=%b required 1 3c 1 0 0",
                         i, rsp0_valid, rsp_data, busy, req1_ready, rsp1_valid);
            end
            if (i < 4) begin
                @(negedge clk); #1;
            end
        end
        rsp0_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got busy=%b rsp0_valid=%b req1_ready=%b required 0 0 1",
                     busy, rsp0_valid, req1_ready);
        end
        @(negedge clk); req1_valid = 1'b0;
        waited = 0;
        @(negedge clk); #1;
        checks++;
        if (rsp1_valid !== 1'b1 || rsp_data !== 8'hC0) begin
            errors++;
            $display("FAIL bp_pending_req1: got rsp1_valid=%b data=%h required 1 c0", rsp1_valid, rsp_data);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_illegal();
        req0_valid = 1'b1; req0_op = 3'd7; req0_a = 8'hFF; req0_b = 8'hFF;
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp_data !== 8'h00 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op: got vld=%b data=%h err=%b required 1 00 1", rsp0_valid, rsp_data, rsp_err);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        // Leave last grant at requester 0 with non-zero data so the reset is observable.
        req0_valid = 1'b1; req0_op = 3'd6; req0_a = 8'hF0; req0_b = 8'hCC;
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp_data !== 8'h0F) begin
            errors++;
            $display("FAIL rst_pre_resp: got vld=%b data=%h required 1 0f", rsp0_valid, rsp_data);
        end
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 8'hF0; req1_b = 8'hCC;
        @(negedge clk); req1_valid = 1'b0; #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_err} !== 6'b0 || rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_async_clear: got rdy=%b%b vld=%b%b busy=%b err=%b data=%h required all zero",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_err, rsp_data);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_resp_%0d: got vld=%b%b busy=%b required 00 0", i, rsp0_valid, rsp1_valid, busy);
            end
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_tie_grant: got ready=%b%b required req0 only", req0_ready, req1_ready);
        end
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = 3'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        test_reset();
        test_single();
        test_all_ops();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1);
    end

endmodule
